// File: rtl/sadd_pkg.sv
// Shared constants and state encoding for the bit-serial adder controller.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package sadd_pkg;

   localparam int SADD_WIDTH_DEF = 8;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_t;

   // Carry of a one-bit full adder.
   function automatic logic maj3(input logic a, input logic b, input logic c);
      return (a & b) | (a & c) | (b & c);
   endfunction

endpackage

// File: rtl/serial_add_ctrl_if.sv
// Request/result bundle between the harness and the serial adder controller.
// Latency: none (wires only).
// Backpressure: none; Start is ignored while Busy is high.
interface serial_add_ctrl_if
   import sadd_pkg::*;
#(
   parameter int WIDTH = SADD_WIDTH_DEF
) ();

   logic             Start;
   logic [WIDTH-1:0] A;
   logic [WIDTH-1:0] B;
   logic             Busy;
   logic             Done;
   logic [WIDTH-1:0] Sum;
   logic             Cout;

   modport master (
      output Start, A, B,
      input  Busy, Done, Sum, Cout
   );

   modport slave (
      input  Start, A, B,
      output Busy, Done, Sum, Cout
   );

endinterface

// File: rtl/carry_ff.sv
// One-bit carry register with synchronous clear and enable.
// Latency: 1 cycle from d_i to q_o when enabled.
// Backpressure: none; clear has priority over enable.
module carry_ff (
   input  logic clk_i,
   input  logic rst_ni,
   input  logic clr_i,
   input  logic en_i,
   input  logic d_i,
   output logic q_o
);

   logic carry_q;

   // Carry state: reset/clear to 0, otherwise load when enabled.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         carry_q <= 1'b0;
      end else if (clr_i) begin
         carry_q <= 1'b0;
      end else if (en_i) begin
         carry_q <= d_i;
      end
   end

   assign q_o = carry_q;

endmodule

// File: rtl/serial_add_ctrl.sv
// Bit-serial adder controller: adds A+B LSB-first over WIDTH cycles.
// Latency: WIDTH+1 cycles from accepting edge to the Done cycle.
// Backpressure: Start ignored while Busy; Start held high restarts every WIDTH+2 cycles.
module serial_add_ctrl
   import sadd_pkg::*;
#(
   parameter int WIDTH = SADD_WIDTH_DEF
) (
   input  logic              Clk,
   input  logic              Reset_n,
   serial_add_ctrl_if.slave  bus
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [CW-1:0] CNT_LAST = CW'(WIDTH - 1);

   state_t           state_q, state_d;
   logic [WIDTH-1:0] areg_q, areg_d;
   logic [WIDTH-1:0] breg_q, breg_d;
   logic [WIDTH-1:0] preg_q, preg_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [WIDTH-1:0] sum_q, sum_d;
   logic             cout_q, cout_d;

   logic             accept;
   logic             shift_en;
   logic             carry_q;
   logic             bit_sum;
   logic             carry_nxt;
   logic [WIDTH-1:0] preg_shift;

   // Full adder on the current LSBs; new sum bit enters the partial sum at the MSB.
   assign bit_sum    = areg_q[0] ^ breg_q[0] ^ carry_q;
   assign carry_nxt  = maj3(areg_q[0], breg_q[0], carry_q);
   assign preg_shift = (preg_q >> 1) | (WIDTH'(bit_sum) << (WIDTH - 1));

   carry_ff u_carry (
      .clk_i  (Clk),
      .rst_ni (Reset_n),
      .clr_i  (accept),
      .en_i   (shift_en),
      .d_i    (carry_nxt),
      .q_o    (carry_q)
   );

   // Next-state and datapath update for IDLE -> SHIFT x WIDTH -> DONE -> IDLE.
   always_comb begin
      state_d  = state_q;
      areg_d   = areg_q;
      breg_d   = breg_q;
      preg_d   = preg_q;
      cnt_d    = cnt_q;
      sum_d    = sum_q;
      cout_d   = cout_q;
      accept   = 1'b0;
      shift_en = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (bus.Start) begin
               accept  = 1'b1;
               areg_d  = bus.A;
               breg_d  = bus.B;
               cnt_d   = '0;
               state_d = S_SHIFT;
            end
         end
         S_SHIFT: begin
            shift_en = 1'b1;
            areg_d   = areg_q >> 1;
            breg_d   = breg_q >> 1;
            preg_d   = preg_shift;
            cnt_d    = cnt_q + CW'(1);
            if (cnt_q == CNT_LAST) begin
               sum_d   = preg_shift;
               cout_d  = carry_nxt;
               state_d = S_DONE;
            end
         end
         S_DONE: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any operation in flight.
   always_ff @(posedge Clk or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= S_IDLE;
         areg_q  <= '0;
         breg_q  <= '0;
         preg_q  <= '0;
         cnt_q   <= '0;
         sum_q   <= '0;
         cout_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         areg_q  <= areg_d;
         breg_q  <= breg_d;
         preg_q  <= preg_d;
         cnt_q   <= cnt_d;
         sum_q   <= sum_d;
         cout_q  <= cout_d;
      end
   end

   // Status decodes come straight from the state register, so no input reaches an output.
   assign bus.Busy = (state_q == S_SHIFT) || (state_q == S_DONE);
   assign bus.Done = (state_q == S_DONE);
   assign bus.Sum  = sum_q;
   assign bus.Cout = cout_q;

endmodule
